// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command bytes and frame helpers.
// Imported by the command transmitter and available to the receive path.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    DATA,
    ACK,
    WAIT_IDLE,
    ERROR
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

  localparam int PS2_FRAME_BITS = 10;

  // Bits shifted out after the start bit, LSB first: data, odd parity, stop.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_command_tx_if.sv
// Command handshake and status bundle between a command source and the PS/2 transmitter.
interface ps2_command_tx_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output cmd_data, cmd_valid,
    input  cmd_ready, busy, tx_done, tx_error
  );

  modport slave (
    input  cmd_data, cmd_valid,
    output cmd_ready, busy, tx_done, tx_error
  );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus a registered
// falling-edge strobe on the synchronized clock (pin-to-strobe latency 3 cycles).
module ps2_line_sync (
  input  logic CLOCK_50,
  input  logic Resetn,
  input  logic clk_pin,
  input  logic dat_pin,
  output logic clk_s,
  output logic dat_s,
  output logic fall
);

  logic [1:0] clk_sync_q, clk_sync_d;
  logic [1:0] dat_sync_q, dat_sync_d;
  logic       clk_prev_q, clk_prev_d;
  logic       fall_q, fall_d;

  always_comb begin
    clk_sync_d = {clk_sync_q[0], clk_pin};
    dat_sync_d = {dat_sync_q[0], dat_pin};
    clk_prev_d = clk_sync_q[1];
    fall_d     = clk_prev_q & ~clk_sync_q[1];
  end

  // Idle bus is pulled high, so reset to "released" to avoid a false edge.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      fall_q     <= fall_d;
    end
  end

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 10 bits on device
// clocks, line-ack check. Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_command_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000
`ifdef PS2_TX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 750000
`endif
) (
  input  logic            CLOCK_50,
  input  logic            Resetn,
  ps2_command_tx_if.slave cmd,
  inout  wire             PS2_CLK,
  inout  wire             PS2_DAT
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

  ps2_state_e                state_q, state_d;
  logic [INH_W-1:0]          inh_cnt_q, inh_cnt_d;
  logic [PS2_FRAME_BITS-1:0] shift_q, shift_d;
  logic [3:0]                bit_cnt_q, bit_cnt_d;
  logic                      clk_oe_q, clk_oe_d;
  logic                      dat_oe_q, dat_oe_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic                      busy_q, busy_d;
  logic                      tx_done_q, tx_done_d;
  logic                      tx_error_q, tx_error_d;

  logic clk_s, dat_s, fall;
  logic timeout;

  ps2_line_sync u_line_sync (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .clk_pin  (PS2_CLK),
    .dat_pin  (PS2_DAT),
    .clk_s    (clk_s),
    .dat_s    (dat_s),
    .fall     (fall)
  );

  // Open-drain: only ever pull low or let go.
  assign PS2_CLK = clk_oe_q ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_oe_q ? 1'b0 : 1'bz;

  assign cmd.cmd_ready = cmd_ready_q;
  assign cmd.busy      = busy_q;
  assign cmd.tx_done   = tx_done_q;
  assign cmd.tx_error  = tx_error_q;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_active;

  assign wd_active = (state_q == RTS) || (state_q == DATA) || (state_q == ACK);

  // Loaded with 1 for the RTS cycle so the error pulse lands TIMEOUT_CYCLES after RTS.
  always_comb begin
    wd_d = '0;
    if (state_q == INHIBIT) begin
      wd_d = WD_W'(1);
    end else if (wd_active) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  assign timeout = wd_active && (wd_q >= WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    inh_cnt_d   = inh_cnt_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    clk_oe_d    = clk_oe_q;
    dat_oe_d    = dat_oe_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    tx_done_d   = 1'b0;
    tx_error_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_oe_d    = 1'b0;
        dat_oe_d    = 1'b0;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        if (cmd.cmd_valid && cmd_ready_q) begin
          shift_d     = ps2_frame(cmd.cmd_data);
          bit_cnt_d   = '0;
          inh_cnt_d   = '0;
          clk_oe_d    = 1'b1;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = INHIBIT;
        end
      end

      INHIBIT: begin
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          state_d  = RTS;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
        end
      end

      RTS: begin
        state_d = DATA;
      end

      DATA: begin
        if (fall) begin
          dat_oe_d  = ~shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 4'd1;
          // Tenth edge places the stop bit; the device acks on the next one.
          if (bit_cnt_q == 4'd9) begin
            state_d = ACK;
          end
        end
      end

      ACK: begin
        dat_oe_d = 1'b0;
        if (fall) begin
          state_d = dat_s ? ERROR : WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          tx_done_d   = 1'b1;
          busy_d      = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      ERROR: begin
        clk_oe_d    = 1'b0;
        dat_oe_d    = 1'b0;
        tx_error_d  = 1'b1;
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (timeout) begin
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      state_d  = ERROR;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      inh_cnt_q   <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      clk_oe_q    <= 1'b0;
      dat_oe_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_error_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      inh_cnt_q   <= inh_cnt_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      clk_oe_q    <= clk_oe_d;
      dat_oe_q    <= dat_oe_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      tx_done_q   <= tx_done_d;
      tx_error_q  <= tx_error_d;
    end
  end

endmodule

// File: tb/tb_ps2_command_tx.sv
// Bench for ps2_command_tx: device clocking model, per-cycle handshake/line checker and
// directed command transfers. Define PS2_TX_TIMEOUT_EN to add the watchdog scenario.
module tb_ps2_command_tx;
  import ps2_pkg::*;

  localparam int N    = 5000;
  localparam int T    = 1000;
  localparam int HALF = 40;

  logic CLOCK_50 = 1'b0;
  logic Resetn;
  wire  PS2_CLK;
  wire  PS2_DAT;
  logic dev_clk_low, dev_dat_low;
  bit   dev_ack;

  ps2_command_tx_if cmd_if ();

  pullup (PS2_CLK);
  pullup (PS2_DAT);
  assign PS2_CLK = dev_clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = dev_dat_low ? 1'b0 : 1'bz;

  always #10 CLOCK_50 = ~CLOCK_50;

`ifdef PS2_TX_TIMEOUT_EN
  ps2_command_tx #(.INHIBIT_CYCLES(N), .TIMEOUT_CYCLES(T)) dut (
`else
  ps2_command_tx #(.INHIBIT_CYCLES(N)) dut (
`endif
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .cmd      (cmd_if.slave),
    .PS2_CLK  (PS2_CLK),
    .PS2_DAT  (PS2_DAT)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit mon_en = 0;

  // Model state: expected busy window and outcome, plus observations for main.
  bit exp_busy = 0;
  bit exp_ack  = 0;
  int k = 0;
  int done_cnt = 0, err_cnt = 0, acc_cnt = 0;
  int pulse_cyc = 0, rts_cyc = 0, inh_len = 0, rts_k = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Device-visible sequence: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    int ones;
    bit par;
    ones = $countones(d);
    par  = (ones % 2 == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  always @(negedge CLOCK_50) begin
    bit c_drv, d_drv;
    cyc++;
    c_drv = (PS2_CLK === 1'b0) && !dev_clk_low;
    d_drv = (PS2_DAT === 1'b0) && !dev_dat_low;
    if (mon_en) begin
      if (exp_busy) begin
        k++;
        if (c_drv) inh_len++;
        if (d_drv && rts_k == 0) rts_k = k;
        if (cmd_if.tx_done || cmd_if.tx_error) begin
          chk("pulse_kind", {30'd0, cmd_if.tx_done, cmd_if.tx_error}, exp_ack ? 32'd2 : 32'd1);
          chk("busy_at_pulse", cmd_if.busy, 0);
          if (cmd_if.tx_done) done_cnt++;
          else err_cnt++;
          pulse_cyc = cyc;
          exp_busy = 0;
        end else begin
          chk("busy_during_tx", cmd_if.busy, 1);
          if (k <= N) begin
            chk("inhibit_clk_low", c_drv, 1);
            chk("inhibit_dat_free", d_drv, 0);
          end else if (k == N + 1) begin
            chk("rts_clk_free", c_drv, 0);
            chk("rts_dat_low", d_drv, 1);
            rts_cyc = cyc;
          end else if (!dev_clk_low) begin
            chk("clk_free_after_rts", c_drv, 0);
          end
        end
      end else begin
        chk("idle_busy", cmd_if.busy, 0);
        chk("idle_done", cmd_if.tx_done, 0);
        chk("idle_error", cmd_if.tx_error, 0);
        chk("idle_clk_free", c_drv, 0);
        chk("idle_dat_free", d_drv, 0);
      end
      chk("ready_vs_busy", cmd_if.cmd_ready, !cmd_if.busy);
      if (!Resetn) begin
        exp_busy = 0;
      end else if (!exp_busy && cmd_if.cmd_valid) begin
        exp_busy = 1;
        exp_ack  = dev_ack;
        k = 0;
        inh_len = 0;
        rts_k = 0;
        acc_cnt++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    cmd_if.cmd_data  = d;
    cmd_if.cmd_valid = 1'b1;
    step(1);
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Keyboard side: waits for request-to-send, then generates n_edges clock pulses,
  // sampling DAT in the high phase before each falling edge.
  task automatic dev_frame(input int n_edges, output logic [10:0] smp);
    int w = 0;
    smp = '0;
    while (!(PS2_CLK === 1'b1 && PS2_DAT === 1'b0) && w < 20000) begin
      step(1);
      w++;
    end
    if (w >= 20000) begin
      chk("rts_seen_timeout", 1, 0);
      return;
    end
    for (int e = 1; e <= n_edges; e++) begin
      step(HALF / 2);
      smp[e-1] = PS2_DAT;
      step(HALF / 4);
      if (e == 11 && dev_ack) dev_dat_low = 1'b1;
      step(HALF / 4);
      dev_clk_low = 1'b1;
      step(HALF);
      dev_clk_low = 1'b0;
    end
    step(5);
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_pulse(input int base, input int bound, input string name);
    int w = 0;
    while (done_cnt + err_cnt == base && w < bound) begin
      @(negedge CLOCK_50);
      #2;
      w++;
    end
    if (w >= bound) chk({name, "_pulse_timeout"}, 1, 0);
    step(1);
  endtask

  task automatic xfer(input logic [7:0] d, input bit ack, output logic [10:0] smp);
    int d0 = done_cnt, e0 = err_cnt;
    dev_ack = ack;
    send(d);
    dev_frame(11, smp);
    wait_pulse(d0 + e0, 3000, "xfer");
    chk("frame_model", smp, exp_frame(d));
    chk("done_delta", done_cnt - d0, ack ? 1 : 0);
    chk("error_delta", err_cnt - e0, ack ? 0 : 1);
    $display("tx %02h ack=%0d: frame=%03h done=%0d err=%0d", d, ack, smp, done_cnt, err_cnt);
  endtask

  initial begin
    logic [10:0] smp;
    int d0, e0;
    Resetn = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_data = 8'h00;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    dev_ack = 1;
    $display("ps2_command_tx bench: device response byte %02h not modelled", PS2_RSP_ACK);
    step(3);
    chk("rst_ready", cmd_if.cmd_ready, 1);
    chk("rst_busy", cmd_if.busy, 0);
    chk("rst_done", cmd_if.tx_done, 0);
    chk("rst_error", cmd_if.tx_error, 0);
    chk("rst_lines", {PS2_CLK, PS2_DAT}, 2'b11);
    mon_en = 1;
    Resetn = 1'b1;
    step(5);

    // Set-LEDs: popcount 6 so parity 1.
    xfer(PS2_CMD_SET_LEDS, 1, smp);
    chk("ed_frame_literal", smp, 11'b11111011010);
    chk("ed_busy_after", cmd_if.busy, 0);

    // Enable: popcount 5 so parity 0; inhibit length measured on the pin.
    xfer(PS2_CMD_ENABLE, 1, smp);
    chk("f4_frame_literal", smp, 11'b10111101000);
    chk("f4_inhibit_len", inh_len, 5000);
    chk("f4_rts_after_accept", rts_k, 5001);

    // No ack from the device.
    xfer(8'h00, 0, smp);
    chk("nak_frame_literal", smp, 11'b11000000000);
    step(2);
    chk("nak_lines_released", {PS2_CLK, PS2_DAT}, 2'b11);

    // Reset partway through a reset command, then a clean enable.
    d0 = done_cnt;
    e0 = err_cnt;
    dev_ack = 1;
    send(PS2_CMD_RESET);
    dev_frame(5, smp);
    chk("ff_first_bits", smp[4:0], 5'b11110);
    Resetn = 1'b0;
    step(1);
    chk("midrst_lines_released", {PS2_CLK, PS2_DAT}, 2'b11);
    step(1);
    Resetn = 1'b1;
    step(50);
    chk("midrst_no_done", done_cnt, d0);
    chk("midrst_no_error", err_cnt, e0);
    $display("tx %02h aborted by reset after 5 edges", PS2_CMD_RESET);
    xfer(PS2_CMD_ENABLE, 1, smp);
    chk("post_rst_f4_literal", smp, 11'b10111101000);

    // Second command held valid during an active transfer.
    dev_ack = 1;
    d0 = done_cnt + err_cnt;
    send(PS2_CMD_SET_LEDS);
    cmd_if.cmd_data = 8'hAA;
    cmd_if.cmd_valid = 1'b1;
    dev_frame(11, smp);
    chk("held_ed_frame_literal", smp, 11'b11111011010);
    d0 = done_cnt + err_cnt - (d0 == done_cnt + err_cnt ? 0 : 1);
    wait_pulse(d0, 3000, "held_ed");
    cmd_if.cmd_valid = 1'b0;
    $display("tx %02h with %02h pending: frame=%03h", PS2_CMD_SET_LEDS, 8'hAA, smp);
    d0 = done_cnt;
    dev_frame(11, smp);
    wait_pulse(d0 + err_cnt, 3000, "queued_aa");
    chk("aa_frame_literal", smp, 11'b11101010100);
    chk("aa_frame_model", smp, exp_frame(8'hAA));
    chk("aa_done", done_cnt - d0, 1);
    chk("accept_count", acc_cnt, 7);
    $display("tx %02h after done: frame=%03h", 8'hAA, smp);

`ifdef PS2_TX_TIMEOUT_EN
    // Silent device: watchdog must end the transfer.
    e0 = err_cnt;
    dev_ack = 0;
    send(PS2_CMD_ENABLE);
    wait_pulse(e0 + done_cnt, 20000, "timeout");
    chk("timeout_error", err_cnt - e0, 1);
    chk("timeout_latency", pulse_cyc - rts_cyc, T);
    chk("timeout_ready", cmd_if.cmd_ready, 1);
    $display("tx %02h timed out after %0d cycles", PS2_CMD_ENABLE, pulse_cyc - rts_cyc);
`endif

    step(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
